// File: rtl/uart_pkg.sv
// Shared types and readdata bit positions for the uart sequencer.
// Positions are functions of the Avalon width so every instance agrees.
package uart_pkg;

   localparam int BYTESIZE_DEF = 8;

   typedef enum logic [1:0] {
      IDLE,
      WR,
      RD
   } state_t;

   function automatic int irq_pos(input int adw);
      return adw - 1;
   endfunction

   function automatic int err_pos(input int adw);
      return adw - 2;
   endfunction

   function automatic int par_pos(input int bytesize);
      return bytesize;
   endfunction

endpackage

// File: rtl/uart_ctl_rr_arb.sv
// Combinational round-robin arbiter.
// Searches upward from ptr with wrap; the pointer register lives in the caller.
module rr_arb #(
   parameter int N_REQ = 4,
   parameter int N_ID  = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [N_ID-1:0]  ptr,
   output logic [N_REQ-1:0] gnt,
   output logic [N_ID-1:0]  idx,
   output logic             any
);

   always_comb begin
      int j;
      gnt = '0;
      idx = '0;
      any = 1'b0;
      for (int k = 0; k < N_REQ; k++) begin
         j = (int'(ptr) + k) % N_REQ;
         if (!any && req[j]) begin
            any    = 1'b1;
            gnt[j] = 1'b1;
            idx    = N_ID'(j);
         end
      end
   end

endmodule

// File: rtl/uart_ctl.sv
// Arbitrates N_REQ byte sources onto the uart transmitter and
// drains received bytes into a single rx stream.
module uart_ctl
   import uart_pkg::*;
#(
   parameter int N_REQ    = 4,
   parameter int N_ID     = $clog2(N_REQ),
   parameter int BYTESIZE = BYTESIZE_DEF,
   parameter int ADW      = 32
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [N_REQ-1:0]          tx_valid,
   input  logic [N_REQ*BYTESIZE-1:0] tx_data,
   output logic [N_REQ-1:0]          tx_ready,
   output logic [N_ID-1:0]           tx_gnt_id,
   output logic                      rx_valid,
   input  logic                      rx_ready,
   output logic [BYTESIZE-1:0]       rx_data,
   output logic                      rx_par,
   output logic                      rx_ovf,
   output logic                      avalon_read,
   output logic                      avalon_write,
   output logic [ADW-1:0]            avalon_writedata,
   input  logic [ADW-1:0]            avalon_readdata,
   input  logic                      avalon_waitrequest,
   input  logic                      status_irq
);

   localparam int IRQ_B = irq_pos(ADW);
   localparam int ERR_B = err_pos(ADW);
   localparam int PAR_B = par_pos(BYTESIZE);

   state_t            state;
   logic [N_ID-1:0]   ptr;
   logic [N_REQ-1:0]  gnt;
   logic [N_ID-1:0]   idx;
   logic              any;
   logic              rx_take;
   logic              unused_rd;

   rr_arb #(
      .N_REQ (N_REQ),
      .N_ID  (N_ID)
   ) u_arb (
      .req (tx_valid),
      .ptr (ptr),
      .gnt (gnt),
      .idx (idx),
      .any (any)
   );

   // Receive has priority so the uart never overflows on our account
   assign rx_take  = status_irq && (!rx_valid || rx_ready);
   assign tx_ready = (state == IDLE && !rx_take) ? gnt : '0;

   assign unused_rd = ^{avalon_readdata[IRQ_B],
                        avalon_readdata[ERR_B-1:PAR_B+1]};

   always_ff @(posedge clk) begin
      if (rst) begin
         state            <= IDLE;
         ptr              <= '0;
         tx_gnt_id        <= '0;
         rx_valid         <= 1'b0;
         rx_data          <= '0;
         rx_par           <= 1'b0;
         rx_ovf           <= 1'b0;
         avalon_read      <= 1'b0;
         avalon_write     <= 1'b0;
         avalon_writedata <= '0;
      end else begin
         if (rx_valid && rx_ready)
            rx_valid <= 1'b0;
         unique case (state)
            IDLE: begin
               if (rx_take) begin
                  avalon_read <= 1'b1;
                  state       <= RD;
               end else if (any) begin
                  avalon_writedata <=
                     ADW'(tx_data[int'(idx)*BYTESIZE +: BYTESIZE]);
                  avalon_write <= 1'b1;
                  tx_gnt_id    <= idx;
                  ptr          <= (idx == N_ID'(N_REQ-1)) ? '0 : idx + 1'b1;
                  state        <= WR;
               end
            end
            WR: begin
               if (!avalon_waitrequest) begin
                  avalon_write <= 1'b0;
                  state        <= IDLE;
               end
            end
            RD: begin
               rx_data     <= avalon_readdata[BYTESIZE-1:0];
               rx_par      <= avalon_readdata[PAR_B];
               rx_ovf      <= avalon_readdata[ERR_B];
               rx_valid    <= 1'b1;
               avalon_read <= 1'b0;
               state       <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/uart_ctl.md
Name: uart_ctl

Overview:
- Sequencer and arbiter in front of the `uart` Avalon MM slave port.
- Shares the transmitter between N_REQ byte requesters using round-robin arbitration over valid/ready streams.
- Drains the receiver automatically: when status_irq is set, reads the byte and presents it on a single rx valid/ready stream.
- Sits between the on-chip byte sources/sinks and one uart instance; it is the only Avalon master of that uart.

Parameters:
- N_REQ, 4, number of transmit requesters (≥2).
- N_ID, $clog2(N_REQ), width of the requester index.
- BYTESIZE, 8, transfer size in bits; must match the uart.
- ADW, 32, Avalon data width; must match the uart.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- tx_valid  in  N_REQ  per-requester byte valid
- tx_data  in  N_REQ*BYTESIZE  per-requester byte; requester i occupies [i*BYTESIZE +: BYTESIZE]
- tx_ready  out  N_REQ  per-requester accept, one-hot or zero
- tx_gnt_id  out  N_ID  index of the last accepted requester
- rx_valid  out  1  received byte available
- rx_ready  in  1  sink accepts the byte
- rx_data  out  BYTESIZE  received byte
- rx_par  out  1  raw parity bit captured from readdata[BYTESIZE]
- rx_ovf  out  1  uart overflow flag captured from readdata[ADW-2]
- avalon_read  out  1  uart read strobe
- avalon_write  out  1  uart write strobe
- avalon_writedata  out  ADW  {zeros, byte}
- avalon_readdata  in  ADW  uart read data: [ADW-1] irq, [ADW-2] err, [BYTESIZE] parity, [BYTESIZE-1:0] data
- avalon_waitrequest  in  1  uart busy (reads never wait)
- status_irq  in  1  uart byte-received flag

Behaviour:
- **Reset values:** all outputs 0 at reset: tx_ready, tx_gnt_id, rx_valid, rx_data, rx_par, rx_ovf, avalon_read, avalon_write, avalon_writedata. Round-robin pointer resets to 0; FSM goes to IDLE.
- **FSM states:** IDLE, WR, RD.
- **IDLE, receive priority:** if status_irq && (!rx_valid || rx_ready), go to RD with avalon_read=1 registered. Receive always wins over transmit so the uart does not overflow.
- **IDLE, transmit:** else if any tx_valid:
  - Pick the first asserted requester at or after the pointer, searching upward with modulo-N_REQ wrap.
  - Pulse tx_ready[i] for that cycle (combinational from the registered FSM state and pointer).
  - Latch tx_data[i] into avalon_writedata, set avalon_write=1, set tx_gnt_id=i, set pointer=(i+1)%N_REQ, go to WR.
- **WR:** hold avalon_write and avalon_writedata stable while avalon_waitrequest=1. The first cycle with waitrequest=0 completes the write: deassert avalon_write, return to IDLE. Write latency from accept to strobe is 1 cycle.
- **RD:** avalon_read=1 for exactly one cycle (the uart never waits a read).
  - In that cycle, capture rx_data=readdata[BYTESIZE-1:0], rx_par=readdata[BYTESIZE], rx_ovf=readdata[ADW-2].
  - Set rx_valid=1, deassert avalon_read, return to IDLE.
  - The uart clears status_irq on that read, so IDLE re-evaluates on fresh status next cycle.
- **rx stream:** rx_valid clears on rx_valid && rx_ready unless a new capture happens in the same cycle; capture wins and rx_valid stays 1. rx_data/rx_par/rx_ovf are stable while rx_valid && !rx_ready.
- **Receive backpressure:** while rx_valid && !rx_ready, no read is issued. The uart then latches its overflow error, which is reported through rx_ovf on the next read.
- **tx stream rules:**
  - At most one tx_ready bit is high per cycle.
  - No tx_ready is asserted outside IDLE.
  - tx_valid deasserted before grant is legal (requester withdraws).
- **Fairness:** with all N_REQ requesters continuously valid and no rx traffic, grants cycle 0,1,…,N_REQ-1,0.
- **Reset mid-operation:** synchronous rst drops avalon_write/avalon_read the next edge and discards any pending rx byte. The uart may be left mid-frame; that is acceptable.

Decomposition:
- uart_pkg holds:
  - the FSM state enum (IDLE/WR/RD);
  - readdata bit-position constants (IRQ=ADW-1, ERR=ADW-2, PAR=BYTESIZE);
  - a default BYTESIZE.
- One sub-module, rr_arb: N_REQ round-robin arbiter with request vector, pointer, one-hot grant and encoded index. It is purely combinational; the pointer register stays in uart_ctl.

Test Plan:
- **Single write:** requester 2 sends 8'hA5 with waitrequest low → tx_ready[2] for 1 cycle; avalon_write for 1 cycle next cycle; writedata=32'h000000A5; tx_gnt_id=2.
- **Wait hold:** waitrequest high for 20 cycles during WR → avalon_write and writedata stable all 20 cycles; completes on the first low cycle; no tx_ready during WR.
- **Round robin:** all 4 requesters valid for 8 writes → grant order 0,1,2,3,0,1,2,3.
- **Receive:** status_irq=1, readdata=32'h80000155 → one avalon_read pulse; then rx_valid=1, rx_data=8'h55, rx_par=1, rx_ovf=0.
- **Priority and backpressure:** status_irq and tx_valid[0] rise together → RD precedes WR. With rx_ready=0 and rx_valid=1, a second irq produces no read. Once rx_ready=1, the next read with readdata[30]=1 gives rx_ovf=1.
- **Reset:** rst asserted in WR → next cycle avalon_write=0, rx_valid=0, pointer=0, state IDLE.
